jam_cost_loader: RTL

//  Upstream feeder for the JAM job-assignment core. Accepts an 8x8 worker/job cost table as a
//  row-major valid/ready stream and stores it in a local register file. Serves JAM's W/J lookups

---
 rtl/jam_pkg.sv | 25 ++
 rtl/jam_row_min.sv | 53 +++++
 rtl/jam_cost_loader.sv | 87 ++++++++
 3 files changed

// File: rtl/jam_pkg.sv
// Shared definitions for the JAM job-assignment core, its cost loader and benches.
//   N_IDX   : workers == jobs per table
//   IDX_W   : width of a worker/job index
//   COST_W  : width of one cost entry
//   SUM_W   : width of the row-minimum lower bound (8*127 fits)
//   ldr_state_t : cost loader FSM states
package jam_pkg;

   localparam int unsigned N_IDX  = 8;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned COST_W = 7;
   localparam int unsigned SUM_W  = 10;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      READY
   } ldr_state_t;

   function automatic logic [COST_W-1:0] cost_min(input logic [COST_W-1:0] a,
                                                   input logic [COST_W-1:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/jam_row_min.sv
// Running row minimum and lower-bound accumulator for the cost loader.
// Only instantiated when JAM_COST_LOADER_ROW_MIN_EN is defined.
//   CLK, RST   : clock, synchronous active-high reset
//   clr        : clears the running minimum and the accumulator (table restart)
//   beat_valid : a cost entry is being written this cycle
//   col        : job index of that entry (0 starts a row, N_IDX-1 ends it)
//   data       : the entry value
//   lb         : registered sum of completed row minima
module jam_row_min
   import jam_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              clr,
   input  logic              beat_valid,
   input  logic [IDX_W-1:0]  col,
   input  logic [COST_W-1:0] data,
   output logic [SUM_W-1:0]  lb
);

   logic [COST_W-1:0] rowmin_q, rowmin_d;
   logic [SUM_W-1:0]  lb_q, lb_d;
   logic [COST_W-1:0] cand;

   always_comb begin
      rowmin_d = rowmin_q;
      lb_d     = lb_q;
      // The first entry of a row seeds the minimum, so no stale value from the previous row leaks in.
      cand     = (col == '0) ? data : cost_min(rowmin_q, data);
      if (clr) begin
         rowmin_d = '0;
         lb_d     = '0;
      end else if (beat_valid) begin
         rowmin_d = cand;
         if (col == IDX_W'(N_IDX - 1)) begin
            lb_d = lb_q + SUM_W'(cand);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         rowmin_q <= '0;
         lb_q     <= '0;
      end else begin
         rowmin_q <= rowmin_d;
         lb_q     <= lb_d;
      end
   end

   assign lb = lb_q;

endmodule

// File: rtl/jam_cost_loader.sv
// Cost table loader for the JAM core: takes an 8x8 cost table as a row-major
// valid/ready stream, stores it, serves combinational lookups and flags completion.
//   CLK, RST   : clock (rising edge), synchronous active-high reset
//   Start      : 1-cycle pulse, (re)start loading a table from entry 0
//   InValid/InReady/InData : input stream; beat k is worker k/8, job k%8
//   W, J       : lookup indices from JAM
//   Cost       : stored entry for {W,J}, zero latency
//   TableReady : a complete table is stored
//   LowerBound : sum of per-worker row minima
// Build option JAM_COST_LOADER_ROW_MIN_EN: enables LowerBound tracking;
// when undefined LowerBound is tied to 0.
module jam_cost_loader
   import jam_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              Start,
   input  logic              InValid,
   output logic              InReady,
   input  logic [COST_W-1:0] InData,
   input  logic [IDX_W-1:0]  W,
   input  logic [IDX_W-1:0]  J,
   output logic [COST_W-1:0] Cost,
   output logic              TableReady,
   output logic [SUM_W-1:0]  LowerBound
);

   localparam int unsigned DEPTH = N_IDX * N_IDX;
   localparam int unsigned CNT_W = 2 * IDX_W;

   ldr_state_t        state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [COST_W-1:0] mem_q [DEPTH];
   logic [COST_W-1:0] mem_d [DEPTH];
   logic              in_ready;
   logic              xfer;

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      mem_d    = mem_q;
      // A Start cycle never accepts a beat, so a restart cannot write a stale entry.
      in_ready = (state_q == LOAD) && !Start;
      xfer     = InValid && in_ready;
      if (Start) begin
         state_d = LOAD;
         count_d = '0;
      end else if (xfer) begin
         mem_d[count_q] = InData;
         count_d        = count_q + 1'b1;
         if (count_q == CNT_W'(DEPTH - 1)) begin
            state_d = READY;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         count_q <= '0;
         mem_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         mem_q   <= mem_d;
      end
   end

   assign InReady    = in_ready;
   assign TableReady = (state_q == READY);
   assign Cost       = mem_q[{W, J}];

`ifdef JAM_COST_LOADER_ROW_MIN_EN
   jam_row_min u_row_min (
      .CLK        (CLK),
      .RST        (RST),
      .clr        (Start),
      .beat_valid (xfer),
      .col        (count_q[IDX_W-1:0]),
      .data       (InData),
      .lb         (LowerBound)
   );
`else
   assign LowerBound = '0;
`endif

endmodule
